// File: rtl/img_proc_pkg.sv
// Shared pixel-pipeline definitions for the image processing stages.
package img_proc_pkg;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned MAX_LINE_W = 1024;
    localparam int unsigned COL_CNT_W  = $clog2(MAX_LINE_W);

    typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/matrix_3x3_8bit_gen_if.sv
// Stream bundle of the 3x3 window generator: pixel input, line-RAM link and window output.
interface matrix_3x3_8bit_gen_if;
    import img_proc_pkg::*;

    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;
    pix_t per_img_y;

    logic line_href;
    logic line_clken;
    pix_t line_shiftin;
    pix_t line_taps0x;
    pix_t line_taps1x;

    logic matrix_frame_vsync;
    logic matrix_frame_href;
    logic matrix_frame_clken;
    pix_t matrix_p11, matrix_p12, matrix_p13;
    pix_t matrix_p21, matrix_p22, matrix_p23;
    pix_t matrix_p31, matrix_p32, matrix_p33;

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        input  line_taps0x, line_taps1x,
        output line_href, line_clken, line_shiftin,
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        output line_taps0x, line_taps1x,
        input  line_href, line_clken, line_shiftin,
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );
endinterface

// File: rtl/matrix_3x3_8bit_gen_row_shift.sv
// One window row: 3-deep enabled shift register, p1 oldest column, p3 newest.
module matrix_row_shift
    import img_proc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  pix_t din_i,
    output pix_t p1_o,
    output pix_t p2_o,
    output pix_t p3_o
);
    pix_t p1_q, p2_q, p3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else if (clr_i) begin
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else if (en_i) begin
            p1_q <= p2_q;
            p2_q <= p3_q;
            p3_q <= din_i;
        end
    end

    assign p1_o = p1_q;
    assign p2_o = p2_q;
    assign p3_o = p3_q;
endmodule

// File: rtl/matrix_3x3_8bit_gen.sv
// 3x3 window generator fed by a two-line shift RAM; timing delayed 2 cycles to match.
// MATRIX_EDGE_MASK_EN enables zero-padded borders (row masking and per-line window clear).
module matrix_3x3_8bit_gen
    import img_proc_pkg::*;
#(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned ROW_CNT_W = 11
) (
    input logic                  clock,
    input logic                  rst_n,
    matrix_3x3_8bit_gen_if.slave bus
);
    localparam logic [COL_CNT_W-1:0] ColMax = COL_CNT_W'(IMG_W - 1);

    logic vsync_d1_q, href_d1_q, clken_d1_q;
    logic vsync_d2_q, href_d2_q, clken_d2_q;
    pix_t row3_q;
    logic [COL_CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    pix_t row1_tap, row2_tap;
    logic win_clr;

    assign bus.line_href    = bus.per_frame_href;
    assign bus.line_clken   = bus.per_frame_clken;
    assign bus.line_shiftin = bus.per_img_y;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1_q <= 1'b0;
            href_d1_q  <= 1'b0;
            clken_d1_q <= 1'b0;
            vsync_d2_q <= 1'b0;
            href_d2_q  <= 1'b0;
            clken_d2_q <= 1'b0;
            row3_q     <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
        end else begin
            vsync_d1_q <= bus.per_frame_vsync;
            href_d1_q  <= bus.per_frame_href;
            clken_d1_q <= bus.per_frame_clken;
            vsync_d2_q <= vsync_d1_q;
            href_d2_q  <= href_d1_q;
            clken_d2_q <= clken_d1_q;
            row3_q     <= bus.per_img_y;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        if (!href_d1_q) begin
            col_cnt_d = '0;
        end else if (clken_d1_q && col_cnt_q != ColMax) begin
            col_cnt_d = col_cnt_q + 1'b1;
        end
    end

    // href_d2 still high while href_d1 is low marks the end of a delayed line.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (!bus.per_frame_vsync) begin
            row_cnt_d = '0;
        end else if (href_d2_q && !href_d1_q && row_cnt_q != '1) begin
            row_cnt_d = row_cnt_q + 1'b1;
        end
    end

`ifdef MATRIX_EDGE_MASK_EN
    assign row1_tap = (row_cnt_q < ROW_CNT_W'(2)) ? '0 : bus.line_taps1x;
    assign row2_tap = (row_cnt_q < ROW_CNT_W'(1)) ? '0 : bus.line_taps0x;
    assign win_clr  = !href_d1_q;
`else
    assign row1_tap = bus.line_taps1x;
    assign row2_tap = bus.line_taps0x;
    assign win_clr  = 1'b0;
`endif

    matrix_row_shift u_row1 (
        .clk_i  (clock),
        .rst_ni (rst_n),
        .en_i   (clken_d1_q),
        .clr_i  (win_clr),
        .din_i  (row1_tap),
        .p1_o   (bus.matrix_p11),
        .p2_o   (bus.matrix_p12),
        .p3_o   (bus.matrix_p13)
    );

    matrix_row_shift u_row2 (
        .clk_i  (clock),
        .rst_ni (rst_n),
        .en_i   (clken_d1_q),
        .clr_i  (win_clr),
        .din_i  (row2_tap),
        .p1_o   (bus.matrix_p21),
        .p2_o   (bus.matrix_p22),
        .p3_o   (bus.matrix_p23)
    );

    matrix_row_shift u_row3 (
        .clk_i  (clock),
        .rst_ni (rst_n),
        .en_i   (clken_d1_q),
        .clr_i  (win_clr),
        .din_i  (row3_q),
        .p1_o   (bus.matrix_p31),
        .p2_o   (bus.matrix_p32),
        .p3_o   (bus.matrix_p33)
    );

    assign bus.matrix_frame_vsync = vsync_d2_q;
    assign bus.matrix_frame_href  = href_d2_q;
    assign bus.matrix_frame_clken = clken_d2_q;
endmodule

// File: tb/tb_matrix_3x3_8bit_gen.sv
// Bench for matrix_3x3_8bit_gen: line-RAM model, stream-level window model, literal pins.
module tb_matrix_3x3_8bit_gen;
    localparam int LW = 8;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    matrix_3x3_8bit_gen_if bus ();

    matrix_3x3_8bit_gen #(
        .IMG_W     (LW),
        .ROW_CNT_W (11)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two-line shift RAM: taps are the pixels LW and 2*LW strobes back, registered on clken.
    logic [7:0] dl [2*LW];
    initial for (int i = 0; i < 2*LW; i++) dl[i] = 8'h00;
    initial begin
        bus.line_taps0x = 8'h00;
        bus.line_taps1x = 8'h00;
    end
    always @(posedge clock) begin
        if (bus.line_clken) begin
            bus.line_taps0x <= dl[LW-1];
            bus.line_taps1x <= dl[2*LW-1];
            dl[0] <= bus.line_shiftin;
            for (int i = 1; i < 2*LW; i++) dl[i] <= dl[i-1];
        end
    end

    // Model: window = last three column triples; triple = (pixel 2*LW back, LW back, now).
    typedef struct packed {logic v; logic h; logic c;} smp_t;
    typedef struct {logic [7:0] w[9]; int tag;} exp_t;
    typedef struct {logic [7:0] t; logic [7:0] m; logic [7:0] b;} tri_t;

    logic [7:0] hist[$];
    tri_t       wl[$];
    exp_t       exp_win[$];
    smp_t       sq[$];
    int frame_id = 0;
    int n_strobes = 0;
    int n_pulses = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sq.delete();
            sq.push_back(3'b000);
            sq.push_back(3'b000);
            exp_win.delete();
        end else begin
            sq.push_back({bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken});
            if (sq.size() > 8) void'(sq.pop_front());
        end
    end

    task automatic model_push(input int r, input int c, input logic [7:0] y);
        int n;
        tri_t tr;
        exp_t e;
        n = hist.size();
        tr.b = y;
        tr.m = (n >= LW) ? hist[n-LW] : 8'h00;
        tr.t = (n >= 2*LW) ? hist[n-2*LW] : 8'h00;
`ifdef MATRIX_EDGE_MASK_EN
        if (c == 0) wl.delete();
        if (r < 1) tr.m = 8'h00;
        if (r < 2) tr.t = 8'h00;
`endif
        hist.push_back(y);
        wl.push_back(tr);
        for (int j = 0; j < 3; j++) begin
            int idx;
            idx = wl.size() - 3 + j;
            e.w[j]   = (idx >= 0) ? wl[idx].t : 8'h00;
            e.w[3+j] = (idx >= 0) ? wl[idx].m : 8'h00;
            e.w[6+j] = (idx >= 0) ? wl[idx].b : 8'h00;
        end
        e.tag = 0;
        if (r == 2 && c == 2 && (frame_id == 0 || frame_id == 3)) e.tag = 1;
        if (r == 0 && c == 0 && frame_id == 0) e.tag = 2;
        if (r == 1 && c == 0 && frame_id == 0) e.tag = 3;
        if (r == 0 && c == 0 && frame_id == 1) e.tag = 4;
        exp_win.push_back(e);
        n_strobes++;
    endtask

    always @(negedge clock) begin
        smp_t e;
        exp_t w;
        logic [7:0] act[9];
        logic [7:0] lit[9];
        if (rst_n && sq.size() >= 2) begin
            e = sq[sq.size()-2];
            chk("vsync_out", int'(bus.matrix_frame_vsync), int'(e.v));
            chk("href_out", int'(bus.matrix_frame_href), int'(e.h));
            chk("clken_out", int'(bus.matrix_frame_clken), int'(e.c));
            chk("line_href", int'(bus.line_href), int'(bus.per_frame_href));
            chk("line_clken", int'(bus.line_clken), int'(bus.per_frame_clken));
            chk("line_shiftin", int'(bus.line_shiftin), int'(bus.per_img_y));
            if (bus.matrix_frame_clken) n_pulses++;
            if (e.c) begin
                if (exp_win.size() == 0) begin
                    chk("win_underflow", 1, 0);
                end else begin
                    w = exp_win.pop_front();
                    act = '{bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
                            bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
                            bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};
                    for (int i = 0; i < 9; i++)
                        chk($sformatf("win_p%0d%0d", i/3+1, i%3+1), int'(act[i]), int'(w.w[i]));
                    if (w.tag == 1) begin
                        lit = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
                        for (int i = 0; i < 9; i++)
                            chk($sformatf("lit22_p%0d%0d", i/3+1, i%3+1), int'(act[i]), int'(lit[i]));
                    end else if (w.tag == 2) begin
                        for (int i = 0; i < 9; i++)
                            chk($sformatf("lit00_p%0d%0d", i/3+1, i%3+1), int'(act[i]), 0);
                    end else if (w.tag == 3) begin
`ifdef MATRIX_EDGE_MASK_EN
                        lit[6] = 8'h00; lit[7] = 8'h00;
`else
                        lit[6] = 8'h06; lit[7] = 8'h07;
`endif
                        lit[8] = 8'h10;
                        for (int i = 6; i < 9; i++)
                            chk($sformatf("lit10_p3%0d", i-5), int'(act[i]), int'(lit[i]));
                    end else if (w.tag == 4) begin
`ifdef MATRIX_EDGE_MASK_EN
                        lit = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
                        lit = '{8'h16, 8'h17, 8'h20, 8'h26, 8'h27, 8'h30, 8'h36, 8'h37, 8'h00};
`endif
                        for (int i = 0; i < 9; i++)
                            chk($sformatf("litnf_p%0d%0d", i/3+1, i%3+1), int'(act[i]), int'(lit[i]));
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic c, input logic [7:0] y);
        @(posedge clock);
        #1;
        bus.per_frame_vsync = v;
        bus.per_frame_href  = h;
        bus.per_frame_clken = c;
        bus.per_img_y       = y;
    endtask

    task automatic strobe(input int r, input int c);
        logic [7:0] y;
        y = 8'(16*r + c);
        model_push(r, c, y);
        drive(1'b1, 1'b1, 1'b1, y);
    endtask

    task automatic run_line(input int r, input bit toggle);
        for (int c = 0; c < LW; c++) begin
            strobe(r, c);
            if (toggle) drive(1'b1, 1'b1, 1'b0, 8'h00);
        end
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_frame(input int fid, input bit toggle);
        frame_id = fid;
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 4; r++) run_line(r, toggle);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string pfx);
        logic [7:0] act[9];
        act = '{bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
                bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
                bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_p%0d%0d", pfx, i/3+1, i%3+1), int'(act[i]), 0);
        chk({pfx, "_vsync"}, int'(bus.matrix_frame_vsync), 0);
        chk({pfx, "_href"}, int'(bus.matrix_frame_href), 0);
        chk({pfx, "_clken"}, int'(bus.matrix_frame_clken), 0);
    endtask

    initial begin
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.per_img_y       = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("por");
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);

        run_frame(0, 1'b0);
        run_frame(1, 1'b1);

        // Frame interrupted by reset at row 2, col 3.
        frame_id = 2;
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
        run_line(0, 1'b0);
        run_line(1, 1'b0);
        for (int c = 0; c < 4; c++) strobe(2, c);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        wl.delete();
        #1;
        chk_all_zero("rst_async");
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("rst_hold");
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);

        run_frame(3, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);

        chk("clken_pulses", n_pulses, n_strobes);
        chk("pending_windows", exp_win.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
